// File: rtl/s2p_param.sv
// Parametrised serial-to-parallel converter with a ready/ack holding register and sticky overrun.
// Optional feature macro: S2P_PARITY_EN (appends one even-parity bit per frame and drives PERR).
module s2p_param #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             D,
    input  logic             DV,
    input  logic             SYNC,
    input  logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             DR,
    output logic             OVR,
    output logic [CW-1:0]    CNT,
    output logic             PERR
);

`ifdef S2P_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_dr;
    logic             r_ovr;

    logic [WIDTH-1:0] w_sr_shift;
    logic [CW-1:0]    w_pos;
    logic             w_last;
    logic             w_data_bit;
    logic [WIDTH-1:0] w_word;
    logic             w_load;
    logic             w_drop;
    logic [CW-1:0]    w_cnt_next;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_sr_shift = {r_sr[WIDTH-2:0], D};
        end else begin : g_lsb
            assign w_sr_shift = {D, r_sr[WIDTH-1:1]};
        end
    endgenerate

    // SYNC makes the current bit (if any) position 0 of a fresh frame.
    assign w_pos  = SYNC ? '0 : r_cnt;
    assign w_last = DV && (w_pos == LAST);

`ifdef S2P_PARITY_EN
    // The trailing parity bit is checked but never shifted into the word.
    assign w_data_bit = DV && (w_pos != CW'(WIDTH));
    assign w_word     = r_sr;
`else
    assign w_data_bit = DV;
    assign w_word     = w_sr_shift;
`endif

    assign w_load = w_last && (!r_dr || ACK);
    assign w_drop = w_last && r_dr && !ACK;

    always_comb begin
        w_cnt_next = r_cnt;
        if (DV) begin
            w_cnt_next = w_last ? '0 : w_pos + 1'b1;
        end else if (SYNC) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_dr  <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_data_bit) begin
                r_sr <= w_sr_shift;
            end
            if (w_load) begin
                r_q  <= w_word;
                r_dr <= 1'b1;
            end else if (ACK) begin
                r_dr <= 1'b0;
            end
            if (w_drop) begin
                r_ovr <= 1'b1;
            end
        end
    end

`ifdef S2P_PARITY_EN
    logic r_perr;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_perr <= 1'b0;
        end else if (w_load) begin
            r_perr <= (^r_sr) ^ D;
        end
    end

    assign PERR = r_perr;
`else
    assign PERR = 1'b0;
`endif

    assign Q   = r_q;
    assign DR  = r_dr;
    assign OVR = r_ovr;
    assign CNT = r_cnt;

endmodule
